seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector, the successor to the fixed-pattern sequence detector. It samples a qualified serial stream MSB-first and compares it against a runtime-loadable pattern of PAT_W bits. It raises a one-cycle flag on each match and supports overlapping and non-overlapping detection modes. It keeps a saturating match counter and sits directly behind the serial data front-end.

Parameters:
PAT_W, 4, pattern length in bits (legal range 2..32).
DEF_PAT, 4'b1101, pattern value loaded at reset (PAT_W bits wide).
CNT_W, 8, width of the saturating match counter.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous, active-low reset
din  input  1  serial data bit
din_vld  input  1  din qualifier; a bit is consumed only when high
pat_load  input  1  load strobe for pat_in
pat_in  input  PAT_W  new pattern; bit PAT_W-1 is the first bit expected on din
mode_ovl  input  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  input  1  synchronous clear of match_cnt
flag  output  1  one-cycle match pulse
match_cnt  output  CNT_W  saturating count of matches
pat_cur  output  PAT_W  currently active pattern

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - hist=0, fill=0, flag=0, match_cnt=0, pat_cur=DEF_PAT.
  - Reset mid-stream discards all partial history.
- Internal state:
  - hist: PAT_W-bit shift register.
  - fill: count of valid bits in hist, saturating at PAT_W, width clog2(PAT_W+1).
  - pat_cur register.
  - match_cnt register.
- Shift: on an edge with din_vld=1 and pat_load=0:
  - hist_n = {hist[PAT_W-2:0], din}.
  - fill_n = min(fill+1, PAT_W).
- Match condition: din_vld=1, pat_load=0, fill_n==PAT_W and hist_n==pat_cur.
  - No match is possible until PAT_W valid bits have been received since reset, pattern load or the last non-overlapped match.
- flag is registered:
  - It is set on the same edge that samples the completing bit, so it is high for exactly the following clock period.
  - Otherwise flag=0. Latency: 0 cycles after the sampling edge.
  - Back-to-back matches (overlap mode, e.g. pattern 1111) produce consecutive high cycles, one per match.
- Overlap mode (mode_ovl=1): after a match, hist_n and fill_n are kept as computed. The match suffix can seed the next match.
- Non-overlap mode (mode_ovl=0): after a match, hist=0 and fill=0. The next match requires PAT_W fresh bits.
- mode_ovl is sampled every cycle. Changing it mid-stream affects only the next match event.
- din_vld=0: hist and fill are held, and flag=0 for the next cycle.
- pat_load=1:
  - pat_cur <= pat_in, hist <= 0, fill <= 0, flag <= 0.
  - din is ignored that cycle even if din_vld=1.
  - pat_load has priority over a simultaneous shift or match.
- match_cnt increments by 1 on each match and saturates at 2^CNT_W-1 (no wrap).
- cnt_clr=1: match_cnt <= 0. If a match occurs in the same cycle, clear wins (count stays 0), but flag still pulses.
- pat_cur always reflects the active pattern register.
- No combinational path from any input to any output.

Decomposition:
- Shared package seq_detect_pkg holds:
  - default constants (DEF_PAT_W=4, DEF_PAT=4'b1101, DEF_CNT_W=8);
  - mode encodings OVL=1'b1, NOVL=1'b0;
  - a clog2-based function for the fill-counter width.
- One natural sub-module, sat_counter (parametrised width, inc and clr inputs, clear priority), instantiated for match_cnt. The shift/compare datapath stays in the top module.

Test Plan:
- Defaults, mode_ovl=1, din_vld=1, stream 1101101 → flag high in the cycles after bits 4 and 7; match_cnt=2.
- Same stream with mode_ovl=0 → flag only after bit 4; match_cnt=1.
- din_vld gaps: 1,1,(vld=0 for 3 cycles with din toggling),0,1 → single flag after the 4th valid bit; no flag during the gap.
- Reset mid-stream: send 110, pulse rst_n low between edges, then send 1 → no flag; match_cnt=0; pat_cur=1101.
- pat_load: send 011, then load pat_in=0110 with din_vld=1 and din=0 in the same cycle, then send 0110 → flag only after the final 0 of the new sequence; the load-cycle bit is not consumed.
- CNT_W=2 build, pattern 11, mode_ovl=1, seven consecutive 1s → six flag pulses and match_cnt saturates at 3. Then cnt_clr coincident with a match → flag=1 and match_cnt=0.

Source files
------------

// File: rtl/seq_detect_param_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_detect_pkg;

  localparam int           DEF_PAT_W = 4;
  localparam logic [3:0]   DEF_PAT   = 4'b1101;
  localparam int           DEF_CNT_W = 8;

  localparam logic OVL  = 1'b1;
  localparam logic NOVL = 1'b0;

  // Fill counter must represent 0..pat_w inclusive.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Stream, pattern-control and result signals of the pattern detector.
interface seq_detect_param_if
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             din;
  logic             din_vld;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             mode_ovl;
  logic             cnt_clr;
  logic             flag;
  logic [CNT_W-1:0] match_cnt;
  logic [PAT_W-1:0] pat_cur;

  modport master (
    output din, din_vld, pat_load, pat_in, mode_ovl, cnt_clr,
    input  flag, match_cnt, pat_cur
  );

  modport slave (
    input  din, din_vld, pat_load, pat_in, mode_ovl, cnt_clr,
    output flag, match_cnt, pat_cur
  );

endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// MSB-first serial pattern detector with runtime-loadable pattern,
// overlapping/non-overlapping modes and a saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seq_detect_pkg::DEF_PAT),
  parameter int               CNT_W   = DEF_CNT_W
) (
  input logic                clk,
  input logic                rst_n,
  seq_detect_param_if.slave  bus
);

  localparam int FILL_W = fill_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              flag_q, flag_d;

  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              match;

  assign hist_shift = {hist_q[PAT_W-2:0], bus.din};
  assign fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

  // The fill check keeps zero-history from matching an all-zero pattern.
  assign match = bus.din_vld && !bus.pat_load &&
                 (fill_inc == FILL_FULL) && (hist_shift == pat_q);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    flag_d = 1'b0;
    if (bus.pat_load) begin
      pat_d  = bus.pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.din_vld) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      if (match) begin
        flag_d = 1'b1;
        if (bus.mode_ovl == NOVL) begin
          hist_d = '0;
          fill_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PAT;
      flag_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      flag_q <= flag_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (match),
    .clr_i (bus.cnt_clr),
    .cnt_o (bus.match_cnt)
  );

  assign bus.flag    = flag_q;
  assign bus.pat_cur = pat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: table of vectors for the default build plus hand-written
// reset and saturation sequences (second instance with PAT_W=2, CNT_W=2).
module tb_seq_detect_param;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_err;

  seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) u_if ();
  seq_detect_param_if #(.PAT_W(2), .CNT_W(2)) u_if2 ();

  seq_detect_param #(.PAT_W(4), .DEF_PAT(4'b1101), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  seq_detect_param #(.PAT_W(2), .DEF_PAT(2'b11), .CNT_W(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       din;
    logic       vld;
    logic       load;
    logic [3:0] pat;
    logic       ovl;
    logic       clr;
    logic       e_flag;
    logic [7:0] e_cnt;
    logic [3:0] e_pat;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic din, input logic vld, input logic load,
                     input logic [3:0] pat, input logic ovl, input logic clr,
                     input logic e_flag, input logic [7:0] e_cnt,
                     input logic [3:0] e_pat);
    vec_t v;
    v.din = din; v.vld = vld; v.load = load; v.pat = pat; v.ovl = ovl;
    v.clr = clr; v.e_flag = e_flag; v.e_cnt = e_cnt; v.e_pat = e_pat;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic drive1(input logic din, input logic vld, input logic load,
                        input logic [3:0] pat, input logic ovl, input logic clr);
    u_if.din = din; u_if.din_vld = vld; u_if.pat_load = load;
    u_if.pat_in = pat; u_if.mode_ovl = ovl; u_if.cnt_clr = clr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive1(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    u_if2.din = 1'b0; u_if2.din_vld = 1'b0; u_if2.pat_load = 1'b0;
    u_if2.pat_in = 2'b00; u_if2.mode_ovl = 1'b1; u_if2.cnt_clr = 1'b0;

    // din vld ld  pat  ovl clr | flag cnt pat
    // overlapping, 1101101
    add(1,1,0,4'h0,1,0, 0,0,4'hD);
    add(1,1,0,4'h0,1,0, 0,0,4'hD);
    add(0,1,0,4'h0,1,0, 0,0,4'hD);
    add(1,1,0,4'h0,1,0, 1,1,4'hD);
    add(1,1,0,4'h0,1,0, 0,1,4'hD);
    add(0,1,0,4'h0,1,0, 0,1,4'hD);
    add(1,1,0,4'h0,1,0, 1,2,4'hD);
    add(1,1,1,4'hD,1,0, 0,2,4'hD);
    // non-overlapping, 1101101
    add(1,1,0,4'h0,0,0, 0,2,4'hD);
    add(1,1,0,4'h0,0,0, 0,2,4'hD);
    add(0,1,0,4'h0,0,0, 0,2,4'hD);
    add(1,1,0,4'h0,0,0, 1,3,4'hD);
    add(1,1,0,4'h0,0,0, 0,3,4'hD);
    add(0,1,0,4'h0,0,0, 0,3,4'hD);
    add(1,1,0,4'h0,0,0, 0,3,4'hD);
    add(1,1,1,4'hD,1,0, 0,3,4'hD);
    // valid gaps with din toggling
    add(1,1,0,4'h0,1,0, 0,3,4'hD);
    add(1,1,0,4'h0,1,0, 0,3,4'hD);
    add(0,0,0,4'h0,1,0, 0,3,4'hD);
    add(1,0,0,4'h0,1,0, 0,3,4'hD);
    add(0,0,0,4'h0,1,0, 0,3,4'hD);
    add(0,1,0,4'h0,1,0, 0,3,4'hD);
    add(1,1,0,4'h0,1,0, 1,4,4'hD);
    add(1,0,0,4'h0,1,0, 0,4,4'hD);
    // 011, load 0110 with a live bit, then 0110
    add(0,1,0,4'h0,1,0, 0,4,4'hD);
    add(1,1,0,4'h0,1,0, 0,4,4'hD);
    add(1,1,0,4'h0,1,0, 0,4,4'hD);
    add(0,1,1,4'h6,1,0, 0,4,4'h6);
    add(0,1,0,4'h0,1,0, 0,4,4'h6);
    add(1,1,0,4'h0,1,0, 0,4,4'h6);
    add(1,1,0,4'h0,1,0, 0,4,4'h6);
    add(0,1,0,4'h0,1,0, 1,5,4'h6);
    // load beats a would-be overlapped match
    add(1,1,0,4'h0,1,0, 0,5,4'h6);
    add(1,1,0,4'h0,1,0, 0,5,4'h6);
    add(0,1,1,4'h6,1,0, 0,5,4'h6);
    // clear alone, then clear coincident with a match
    add(0,0,0,4'h0,1,1, 0,0,4'h6);
    add(0,1,0,4'h0,1,0, 0,0,4'h6);
    add(1,1,0,4'h0,1,0, 0,0,4'h6);
    add(1,1,0,4'h0,1,0, 0,0,4'h6);
    add(0,1,0,4'h0,1,1, 1,0,4'h6);

    #12;
    check("rst_flag", 32'(u_if.flag), 32'd0);
    check("rst_cnt", 32'(u_if.match_cnt), 32'd0);
    check("rst_pat", 32'(u_if.pat_cur), 32'hD);
    check("rst_pat2", 32'(u_if2.pat_cur), 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vq[i]) begin
      drive1(vq[i].din, vq[i].vld, vq[i].load, vq[i].pat, vq[i].ovl, vq[i].clr);
      tick();
      check($sformatf("v%0d_flag", i), 32'(u_if.flag), 32'(vq[i].e_flag));
      check($sformatf("v%0d_cnt", i), 32'(u_if.match_cnt), 32'(vq[i].e_cnt));
      check($sformatf("v%0d_pat", i), 32'(u_if.pat_cur), 32'(vq[i].e_pat));
    end

    // Reset mid-stream: 110, reset between edges, then 1 -> no match.
    drive1(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    drive1(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0); tick();
    drive1(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0); tick();
    drive1(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0); tick();
    rst_n = 1'b0;
    #2;
    check("midrst_flag", 32'(u_if.flag), 32'd0);
    rst_n = 1'b1;
    drive1(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    check("midrst_flag_after", 32'(u_if.flag), 32'd0);
    check("midrst_cnt", 32'(u_if.match_cnt), 32'd0);
    check("midrst_pat", 32'(u_if.pat_cur), 32'hD);
    drive1(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Narrow build: pattern 11, seven 1s -> six flags, count saturates at 3.
    u_if2.din = 1'b1;
    u_if2.din_vld = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("sat%0d_flag", k), 32'(u_if2.flag), (k >= 1) ? 32'd1 : 32'd0);
      check($sformatf("sat%0d_cnt", k), 32'(u_if2.match_cnt), (k >= 3) ? 32'd3 : 32'(k));
    end
    u_if2.cnt_clr = 1'b1;
    tick();
    check("sat_clr_flag", 32'(u_if2.flag), 32'd1);
    check("sat_clr_cnt", 32'(u_if2.match_cnt), 32'd0);
    u_if2.cnt_clr = 1'b0;
    u_if2.din_vld = 1'b0;
    tick();
    check("sat_idle_flag", 32'(u_if2.flag), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
